banked_register_file: RTL and testbench
=======================================

# banked_register_file

Parametrised successor to the CPU's public register file: `NUM_REGS` registers of `WIDTH` bits, two tri-state read ports (A/B buses), one write port (result bus) and hardware SP/PC auto-increment/decrement. The stack pointer is banked per CPU mode (user/supervisor), so interrupt entry never corrupts the user stack. Over/underflow of either SP bank sets a sticky fault flag for the control unit. It sits between the result bus and the A/B register buses, driven by control signals from the control unit, which runs on the inverted clock.

## Interface
- `WIDTH`, 32, register and bus width
- `NUM_REGS`, 16, architectural register count (≥ 3)
- `SP_IDX`, 14, index of the banked stack pointer
- `PC_IDX`, 15, index of the program counter
- `SP_RESET`, 0, reset value of both SP banks
- `PC_RESET`, 0, reset value of PC
- `clk` in 1: single clock; all state updates on posedge
- `rst` in 1: asynchronous, active-high reset
- `a`, `b` out tri `WIDTH`: read ports; high-Z unless `oe_a`/`oe_b`
- `in` in `WIDTH`: write data (result bus)
- `oe_a`, `oe_b`, `ld` in 1: read-port enables, write enable
- `sel_a`, `sel_b`, `sel_in` in `SEL_W = $clog2(NUM_REGS)`: register selects
- `mode` in `cpu_mode_e`: selects the SP bank (`USER` / `SUPERVISOR`)
- `sp_post_inc`, `sp_pre_dec`, `pc_post_inc` in 1: auto-update strobes
- `clr_fault` in 1: clears `sp_fault`
- `sp_value`, `pc_value` out `WIDTH`: current-mode SP and PC, always driven
- `sp_fault` out 1: sticky SP over/underflow or illegal-strobe flag

## Operation
- Read view: index `SP_IDX` maps to `sp_bank[mode]`; every other index maps to its single register.
- Reads are combinational. When `sp_pre_dec=1`, both ports and `sp_value` return SP−1 for `SP_IDX`; otherwise they return the stored value.
- If `sel ≥ NUM_REGS`, reads return 0 and writes are ignored.
- On posedge with `ld=1`: `reg[sel_in] ← in`. When `sel_in=SP_IDX`, only the current-mode bank is written.
- On posedge with `sp_post_inc`: SP ← SP+1. With `sp_pre_dec`: SP ← SP−1. Only the current-mode bank is updated; the other bank holds.
- On posedge with `pc_post_inc`: PC ← PC+1. Reads in that cycle return the old PC.
- Precedence: an `ld` to the same register overrides its auto-update. Auto-updates to other registers still apply.
- Illegal strobes (`sp_post_inc` and `sp_pre_dec` both high): SP unchanged, reads unaltered, `sp_fault` set.
- Arithmetic is modulo 2^`WIDTH`; the result wraps.
  - SP inc from all-ones sets `sp_fault`.
  - SP dec from 0 sets `sp_fault`.
  - PC wrap is silent.
- Fault flag:
  - `clr_fault` clears `sp_fault` at the posedge.
  - A new fault in the same cycle as `clr_fault` wins, so the flag stays 1.
- Reset values:
  - All general registers are 0.
  - Both SP banks are `SP_RESET`; PC is `PC_RESET`.
  - `sp_fault` is 0; `a`/`b` follow the `oe` inputs.

## Timing
- Read latency: 0 cycles (combinational from `sel`/`oe`/`mode`/`sp_pre_dec`).
- Write / auto-update latency: visible on reads 1 posedge later.
- Control inputs change after the negedge, driven by the control unit, and must be stable before the posedge.
- A `mode` change re-maps SP reads immediately. A write in the same cycle uses the `mode` sampled at the posedge.
- Reset is asynchronous: assertion clears state immediately, mid-cycle or mid-operation, with no pending update retained. Deassertion is synchronous to `clk` (the system guarantees this).

## Structure
- `cpu_pkg` holds `cpu_mode_e` (existing). `reg_pkg` gains `SP_IDX`/`PC_IDX` defaults and the `sp_bank_t` array type.
- Natural sub-module `auto_inc_reg`, instantiated for PC and each SP bank. It provides load, inc, pre-dec view, and a wrap-detect output.
- Tri-state drive is done at the top level only. Target size is about 200 lines.

## Test plan
- Reset then read all registers: general registers = 0, SP = `SP_RESET`, PC = `PC_RESET`, `a`/`b` = Z with `oe` low, `sp_fault` = 0.
- `ld` r3 ← 0xDEADBEEF, then `sel_a=3`, `sel_b=3` with both `oe` high: both ports read 0xDEADBEEF. Same cycle `pc_post_inc` from PC=0x10: PC = 0x11 next cycle.
- USER mode: `ld` SP ← 0x100. Switch to SUPERVISOR and `ld` SP ← 0x200. Back to USER: SP reads 0x100; `sp_pre_dec` reads 0xFF and stores 0xFF, while the SUPERVISOR bank holds 0x200.
- SP = 0, `sp_pre_dec`: read returns 0xFFFFFFFF, SP wraps, `sp_fault` = 1. It stays 1 until `clr_fault`; `clr_fault` plus a fresh overflow keeps it 1.
- `ld` to PC_IDX with `in`=0x40 together with `pc_post_inc`: PC = 0x40 (load wins). `sp_post_inc` with `sp_pre_dec`: SP unchanged, fault set.
- Assert `rst` mid-cycle after `ld` setup: state clears immediately and the pending write is not applied after release.

Source files
------------

// File: rtl/banked_register_file_pkg.sv
// Shared types and default geometry for the banked register file.
// cpu_mode_e selects which stack-pointer bank is visible.
package banked_register_file_pkg;

  typedef enum logic {
    USER       = 1'b0,
    SUPERVISOR = 1'b1
  } cpu_mode_e;

  localparam int NUM_BANKS    = 2;
  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_SP_IDX   = 14;
  localparam int DEF_PC_IDX   = 15;

endpackage

// File: rtl/banked_register_file_if.sv
// Control/result bus between the control unit and the register file.
// The tri-state A/B buses stay as plain top-level ports.
interface banked_register_file_if
  import banked_register_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = $clog2(DEF_NUM_REGS)
);
  logic [WIDTH-1:0] in;
  logic             oe_a;
  logic             oe_b;
  logic             ld;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic [SEL_W-1:0] sel_in;
  cpu_mode_e        mode;
  logic             sp_post_inc;
  logic             sp_pre_dec;
  logic             pc_post_inc;
  logic             clr_fault;
  logic [WIDTH-1:0] sp_value;
  logic [WIDTH-1:0] pc_value;
  logic             sp_fault;

  modport master (
    output in, oe_a, oe_b, ld, sel_a, sel_b, sel_in, mode,
           sp_post_inc, sp_pre_dec, pc_post_inc, clr_fault,
    input  sp_value, pc_value, sp_fault
  );

  modport slave (
    input  in, oe_a, oe_b, ld, sel_a, sel_b, sel_in, mode,
           sp_post_inc, sp_pre_dec, pc_post_inc, clr_fault,
    output sp_value, pc_value, sp_fault
  );
endinterface

// File: rtl/banked_register_file_auto_inc_reg.sv
// Register with load / increment / decrement, a combinational pre-decrement
// view and a wrap flag for the update requested this cycle.
module banked_register_file_auto_inc_reg #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] dec_view,
  output logic             wrap
);
    assign dec_view = q - WIDTH'(1);
    // Wrap is reported from the strobe even if a load overrides the update.
    assign wrap     = (inc && (&q)) || (dec && (q == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= RESET;
        else if (ld)  q <= ld_data;
        else if (inc) q <= q + WIDTH'(1);
        else if (dec) q <= q - WIDTH'(1);
    end
endmodule

// File: rtl/banked_register_file.sv
// Register file with two tri-state read ports, one write port, a per-mode
// banked SP with auto inc/pre-dec, an auto-incrementing PC and a sticky SP fault.
module banked_register_file
  import banked_register_file_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter int               NUM_REGS = DEF_NUM_REGS,
  parameter int               SP_IDX   = DEF_SP_IDX,
  parameter int               PC_IDX   = DEF_PC_IDX,
  parameter logic [WIDTH-1:0] SP_RESET = '0,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  output tri [WIDTH-1:0]   a,
  output tri [WIDTH-1:0]   b,
  banked_register_file_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0][WIDTH-1:0]  gpr;
    logic [NUM_BANKS-1:0][WIDTH-1:0] sp_q;
    logic [NUM_BANKS-1:0][WIDTH-1:0] sp_dv;
    logic [NUM_BANKS-1:0]            sp_wrap;
    logic [NUM_BANKS-1:0]            bank_sel;
    logic [WIDTH-1:0]                pc_q;
    logic [WIDTH-1:0]                pc_dec_view_unused;
    logic                            pc_wrap_unused;
    logic [WIDTH-1:0]                sp_view, rd_a, rd_b;
    logic                            sp_inc, sp_dec, sp_illegal;
    logic                            ld_ok, ld_sp, ld_pc, ld_gpr;

    // Both strobes together is illegal: neither update nor pre-dec view applies.
    assign sp_illegal = bus.sp_post_inc & bus.sp_pre_dec;
    assign sp_inc     = bus.sp_post_inc & ~bus.sp_pre_dec;
    assign sp_dec     = bus.sp_pre_dec & ~bus.sp_post_inc;

    assign bank_sel[0] = (bus.mode == USER);
    assign bank_sel[1] = (bus.mode == SUPERVISOR);

    assign ld_ok  = bus.ld && (32'(bus.sel_in) < NUM_REGS);
    assign ld_sp  = ld_ok && (32'(bus.sel_in) == SP_IDX);
    assign ld_pc  = ld_ok && (32'(bus.sel_in) == PC_IDX);
    assign ld_gpr = ld_ok && !ld_sp && !ld_pc;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_sp
        banked_register_file_auto_inc_reg #(.WIDTH(WIDTH), .RESET(SP_RESET)) u_sp (
            .clk      (clk),
            .rst      (rst),
            .ld       (ld_sp && bank_sel[g]),
            .ld_data  (bus.in),
            .inc      (sp_inc && bank_sel[g]),
            .dec      (sp_dec && bank_sel[g]),
            .q        (sp_q[g]),
            .dec_view (sp_dv[g]),
            .wrap     (sp_wrap[g])
        );
    end

    banked_register_file_auto_inc_reg #(.WIDTH(WIDTH), .RESET(PC_RESET)) u_pc (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld_pc),
        .ld_data  (bus.in),
        .inc      (bus.pc_post_inc),
        .dec      (1'b0),
        .q        (pc_q),
        .dec_view (pc_dec_view_unused),
        .wrap     (pc_wrap_unused)
    );

    // SP/PC slots of gpr are never written and read as don't-care.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         gpr <= '0;
        else if (ld_gpr) gpr[bus.sel_in] <= bus.in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.sp_fault <= 1'b0;
        else     bus.sp_fault <= (bus.sp_fault & ~bus.clr_fault) | sp_illegal | (|sp_wrap);
    end

    function automatic logic [WIDTH-1:0] rd(input logic [SEL_W-1:0] sel,
                                            input logic [WIDTH-1:0] spv,
                                            input logic [WIDTH-1:0] pcv,
                                            input logic [NUM_REGS-1:0][WIDTH-1:0] regs);
        if (32'(sel) >= NUM_REGS)     return '0;
        else if (32'(sel) == SP_IDX)  return spv;
        else if (32'(sel) == PC_IDX)  return pcv;
        else                          return regs[sel];
    endfunction

    always_comb begin
        sp_view = sp_dec ? sp_dv[bus.mode] : sp_q[bus.mode];
        rd_a    = rd(bus.sel_a, sp_view, pc_q, gpr);
        rd_b    = rd(bus.sel_b, sp_view, pc_q, gpr);
    end

    assign bus.sp_value = sp_view;
    assign bus.pc_value = pc_q;

    assign a = bus.oe_a ? rd_a : 'z;
    assign b = bus.oe_b ? rd_b : 'z;
endmodule

// File: tb/tb_banked_register_file.sv
// Scoreboard bench: driver pushes model-predicted reads per cycle, monitor
// samples the DUT before the posedge and compares.
module tb_banked_register_file;
  import banked_register_file_pkg::*;

  localparam int W  = 32;
  localparam int NR = 16;
  localparam int SP = 14;
  localparam int PC = 15;

  typedef struct {
    logic [W-1:0] din;
    bit           oe_a, oe_b, ld;
    int           sel_a, sel_b, sel_in;
    cpu_mode_e    mode;
    bit           post, pre, pc_inc, clr;
  } stim_t;

  typedef struct {
    logic [W-1:0] a, b, sp, pc;
    logic         fault;
    bit           oe_a, oe_b;
    int           id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  tri [W-1:0] a, b;
  banked_register_file_if #(.WIDTH(W), .SEL_W(4)) bus ();

  banked_register_file dut (.clk(clk), .rst(rst), .a(a), .b(b), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: architectural state as plain arrays.
  logic [W-1:0] m_reg [NR];
  logic [W-1:0] m_sp  [2];
  logic [W-1:0] m_pc;
  bit           m_fault;

  exp_t sbq [$];
  int   n_cmp = 0, n_bad = 0, n_id = 0;

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) m_reg[i] = '0;
    m_sp[0] = '0; m_sp[1] = '0; m_pc = '0; m_fault = 0;
  endfunction

  function automatic logic [W-1:0] m_sp_view(stim_t s);
    if (s.pre && !s.post) return m_sp[s.mode] - 1;
    return m_sp[s.mode];
  endfunction

  function automatic logic [W-1:0] m_read(int sel, stim_t s);
    if (sel >= NR) return '0;
    if (sel == SP) return m_sp_view(s);
    if (sel == PC) return m_pc;
    return m_reg[sel];
  endfunction

  function automatic exp_t expect_of(stim_t s);
    exp_t e;
    e.oe_a = s.oe_a; e.oe_b = s.oe_b;
    e.a = s.oe_a ? m_read(s.sel_a, s) : 'z;
    e.b = s.oe_b ? m_read(s.sel_b, s) : 'z;
    e.sp = m_sp_view(s); e.pc = m_pc; e.fault = m_fault;
    e.id = n_id;
    return e;
  endfunction

  function automatic void model_update(stim_t s);
    int  k = int'(s.mode);
    bit  nf = 0;
    if (s.post && s.pre) nf = 1;
    else if (s.post) begin nf = (m_sp[k] == {W{1'b1}}); m_sp[k] = m_sp[k] + 1; end
    else if (s.pre)  begin nf = (m_sp[k] == '0);       m_sp[k] = m_sp[k] - 1; end
    if (s.pc_inc) m_pc = m_pc + 1;
    if (s.ld && s.sel_in < NR) begin
      if (s.sel_in == SP)      m_sp[k] = s.din;
      else if (s.sel_in == PC) m_pc = s.din;
      else                     m_reg[s.sel_in] = s.din;
    end
    m_fault = nf || (m_fault && !s.clr);
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.din = '0; s.oe_a = 0; s.oe_b = 0; s.ld = 0;
    s.sel_a = 0; s.sel_b = 0; s.sel_in = 0; s.mode = USER;
    s.post = 0; s.pre = 0; s.pc_inc = 0; s.clr = 0;
    return s;
  endfunction

  task automatic apply(stim_t s);
    bus.in = s.din; bus.oe_a = s.oe_a; bus.oe_b = s.oe_b; bus.ld = s.ld;
    bus.sel_a = 4'(s.sel_a); bus.sel_b = 4'(s.sel_b); bus.sel_in = 4'(s.sel_in);
    bus.mode = s.mode; bus.sp_post_inc = s.post; bus.sp_pre_dec = s.pre;
    bus.pc_post_inc = s.pc_inc; bus.clr_fault = s.clr;
  endtask

  task automatic step(stim_t s);
    @(negedge clk);
    apply(s);
    n_id++;
    sbq.push_back(expect_of(s));
    model_update(s);
  endtask

  task automatic chk(string nm, int id, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got %h want %h", nm, id, act, exp);
    end
  endtask

  // Monitor: samples 3ns after negedge, 2ns before the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk(e.oe_a ? "port_a" : "port_a_z", e.id, a, e.a);
        chk(e.oe_b ? "port_b" : "port_b_z", e.id, b, e.b);
        chk("sp_value", e.id, bus.sp_value, e.sp);
        chk("pc_value", e.id, bus.pc_value, e.pc);
        chk("sp_fault", e.id, {31'b0, bus.sp_fault}, {31'b0, e.fault});
      end
    end
  end

  initial begin
    stim_t s;
    model_reset();
    apply(idle());
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset contents on both ports, then high-Z with enables low.
    for (int i = 0; i < NR; i++) begin
      s = idle(); s.sel_a = i; s.sel_b = NR - 1 - i; s.oe_a = 1; s.oe_b = 1;
      step(s);
    end
    step(idle());

    // PC <- 0x10, then r3 load together with pc_post_inc, then read r3 on both ports.
    s = idle(); s.ld = 1; s.sel_in = PC; s.din = 32'h10; step(s);
    s = idle(); s.ld = 1; s.sel_in = 3; s.din = 32'hDEADBEEF; s.pc_inc = 1; step(s);
    s = idle(); s.sel_a = 3; s.sel_b = 3; s.oe_a = 1; s.oe_b = 1; step(s);

    // Banked SP: user 0x100, supervisor 0x200, user pre-dec to 0xFF.
    s = idle(); s.ld = 1; s.sel_in = SP; s.din = 32'h100; s.mode = USER; step(s);
    s = idle(); s.ld = 1; s.sel_in = SP; s.din = 32'h200; s.mode = SUPERVISOR; step(s);
    s = idle(); s.sel_a = SP; s.oe_a = 1; s.mode = USER; step(s);
    s = idle(); s.sel_a = SP; s.sel_b = SP; s.oe_a = 1; s.oe_b = 1; s.pre = 1; step(s);
    s = idle(); s.sel_a = SP; s.oe_a = 1; step(s);
    s = idle(); s.sel_a = SP; s.oe_a = 1; s.mode = SUPERVISOR; step(s);

    // Underflow from 0, sticky fault, clear, then clear racing a fresh overflow.
    s = idle(); s.ld = 1; s.sel_in = SP; s.din = '0; step(s);
    s = idle(); s.sel_a = SP; s.oe_a = 1; s.pre = 1; step(s);
    s = idle(); s.sel_a = SP; s.oe_a = 1; step(s);
    step(idle());
    s = idle(); s.clr = 1; step(s);
    s = idle(); s.ld = 1; s.sel_in = SP; s.din = '1; step(s);
    s = idle(); s.post = 1; s.clr = 1; step(s);
    s = idle(); s.sel_b = SP; s.oe_b = 1; step(s);
    s = idle(); s.clr = 1; step(s);

    // Load beats pc_post_inc; illegal SP strobe pair.
    s = idle(); s.ld = 1; s.sel_in = PC; s.din = 32'h40; s.pc_inc = 1; step(s);
    s = idle(); s.sel_a = PC; s.sel_b = SP; s.oe_a = 1; s.oe_b = 1; s.post = 1; s.pre = 1; step(s);
    s = idle(); s.sel_b = SP; s.oe_b = 1; step(s);

    // Randomized traffic with boundary-biased data.
    for (int n = 0; n < 600; n++) begin
      s = idle();
      case ($urandom_range(0, 3))
        0: s.din = '0;
        1: s.din = '1;
        2: s.din = $urandom();
        default: s.din = 32'($urandom_range(0, 3));
      endcase
      s.ld = ($urandom_range(0, 2) == 0);
      s.sel_in = $urandom_range(0, NR - 1);
      s.sel_a = $urandom_range(0, NR - 1);
      s.sel_b = ($urandom_range(0, 1) == 0) ? SP : $urandom_range(0, NR - 1);
      s.oe_a = ($urandom_range(0, 3) != 0);
      s.oe_b = ($urandom_range(0, 3) != 0);
      s.mode = cpu_mode_e'($urandom_range(0, 1));
      s.post = ($urandom_range(0, 3) == 0);
      s.pre = ($urandom_range(0, 3) == 0);
      s.pc_inc = ($urandom_range(0, 2) == 0);
      s.clr = ($urandom_range(0, 7) == 0);
      step(s);
    end

    // Asynchronous reset between setup of a write and its posedge.
    s = idle(); s.ld = 1; s.sel_in = 5; s.din = 32'h1111; step(s);
    s = idle(); s.ld = 1; s.sel_in = 5; s.din = 32'hA5A5A5A5; s.post = 1; s.pc_inc = 1;
    s.sel_a = 5; s.sel_b = SP; s.oe_a = 1; s.oe_b = 1;
    @(negedge clk);
    apply(s);
    #2;
    rst = 1'b1;
    model_reset();
    n_id++;
    sbq.push_back(expect_of(s));
    @(negedge clk);
    s = idle(); s.sel_a = 5; s.sel_b = PC; s.oe_a = 1; s.oe_b = 1;
    apply(s);
    rst = 1'b0;
    step(s);
    step(s);

    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
